steer_quad_gen: RTL and testbench

//  Generates the 2-bit Gray-code quadrature pair (Steer_xA/Steer_xB) that the sprint2 core samples as a steering wheel.
//  Two motion sources:
//  - digital left/right, with an accelerating step rate while held;
//  - signed paddle/spinner deltas, delivered over a valid/ready handshake.
//  One instance per player, clocked from the 6 MHz video clock, driving Steer_nA_I/Steer_nB_I.

---
 rtl/steer_quad_gen.sv | 193 +++++++++++++++++++
 tb/tb_steer_quad_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/steer_quad_gen.sv
// steer_quad_gen
//   Produces the 2-bit Gray-code quadrature pair that the sprint2 core reads
//   as one player's steering wheel. There are two sources of motion:
//   - Digital left/right keys. The first step is immediate. While a key is
//     held, the step period shrinks after every step, down to a floor.
//   - Signed paddle/spinner deltas over a valid/ready handshake. Each delta
//     is played out as |delta| steps at the fixed floor period.
//
// Ports
//   CLK          core clock (6 MHz video clock)
//   reset        asynchronous, active-high
//   ce           step-timing enable; counters and steps advance only when high
//   left, right  joystick keys, active-high; both pressed counts as idle
//   delta        signed step count, positive = right
//   delta_valid  a delta is offered
//   delta_ready  a delta is taken on an edge where valid & ready
//   steer        {A,B} quadrature, Gray coded from the internal phase
//   moving       high while a joystick or paddle motion is in progress
//   dir          direction of the last step, 1 = right/positive

module steer_quad_gen #(
  parameter int CLKDIV_MAX = 22500,
  parameter int CLKDIV_MIN = 5625,
  parameter int RAMP_STEP  = 1125,
  parameter int DELTA_W    = 8
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      ce,
  input  logic                      left,
  input  logic                      right,
  input  logic signed [DELTA_W-1:0] delta,
  input  logic                      delta_valid,
  output logic                      delta_ready,
  output logic [1:0]                steer,
  output logic                      moving,
  output logic                      dir
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_JOY  = 2'd1;
  localparam logic [1:0] ST_PAD  = 2'd2;

  localparam logic [15:0] PERIOD_MAX = 16'(CLKDIV_MAX);
  localparam logic [15:0] PERIOD_MIN = 16'(CLKDIV_MIN);
  localparam logic [15:0] PAD_LAST   = 16'(CLKDIV_MIN - 1);
  localparam logic [15:0] RAMP       = 16'(RAMP_STEP);
  // The ramp may only subtract while the result stays at or above the floor.
  // The comparison is done one bit wider so that it can never wrap.
  localparam logic [16:0] RAMP_FLOOR = 17'(CLKDIV_MIN + RAMP_STEP);

  logic [1:0]         state, state_n;
  logic [1:0]         phase, phase_n;
  logic [15:0]        cnt, cnt_n;
  logic [15:0]        period, period_n;
  logic [15:0]        period_ramped;
  logic [DELTA_W-1:0] pending, pending_n;
  logic [DELTA_W-1:0] delta_mag;
  logic               dir_n;
  logic               ready_n;
  logic               joy_active;
  logic               step;
  logic               step_right;

  assign joy_active = left ^ right;
  assign steer      = {phase[1], phase[1] ^ phase[0]};

  // The magnitude is unsigned and DELTA_W bits wide, so the most negative
  // delta maps to 2^(DELTA_W-1) without overflowing.
  assign delta_mag = delta[DELTA_W-1] ? DELTA_W'(~delta + 1'b1) : DELTA_W'(delta);

  assign period_ramped = ({1'b0, period} >= RAMP_FLOOR) ? (period - RAMP) : PERIOD_MIN;

  // Next-state logic. Every joystick entry (from IDLE, from PAD, or on a
  // reversal) takes one immediate step and restarts the ramp from the
  // slowest period.
  always_comb begin
    state_n    = state;
    phase_n    = phase;
    cnt_n      = cnt;
    period_n   = period;
    pending_n  = pending;
    dir_n      = dir;
    step       = 1'b0;
    step_right = dir;

    case (state)
      ST_IDLE: begin
        if (ce && joy_active) begin
          state_n    = ST_JOY;
          step       = 1'b1;
          step_right = right;
          dir_n      = right;
          cnt_n      = 16'd0;
          period_n   = PERIOD_MAX;
        end else if (delta_valid && delta_ready) begin
          pending_n = delta_mag;
          dir_n     = ~delta[DELTA_W-1];
          if (delta_mag != '0) begin
            // Preloading the counter makes the first paddle step fire on the next ce.
            state_n = ST_PAD;
            cnt_n   = PAD_LAST;
          end
        end
      end

      ST_JOY: begin
        if (!joy_active) begin
          state_n  = ST_IDLE;
          cnt_n    = 16'd0;
          period_n = PERIOD_MAX;
        end else if (ce) begin
          if (right != dir) begin
            step       = 1'b1;
            step_right = right;
            dir_n      = right;
            cnt_n      = 16'd0;
            period_n   = PERIOD_MAX;
          end else if (cnt == period - 16'd1) begin
            step       = 1'b1;
            step_right = dir;
            cnt_n      = 16'd0;
            period_n   = period_ramped;
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end
      end

      ST_PAD: begin
        if (ce) begin
          if (joy_active) begin
            // The joystick overrides the paddle: the remaining steps are dropped.
            pending_n  = '0;
            state_n    = ST_JOY;
            step       = 1'b1;
            step_right = right;
            dir_n      = right;
            cnt_n      = 16'd0;
            period_n   = PERIOD_MAX;
          end else if (cnt == PAD_LAST) begin
            step       = 1'b1;
            step_right = dir;
            cnt_n      = 16'd0;
            pending_n  = pending - 1'b1;
            if (pending == DELTA_W'(1)) begin
              state_n = ST_IDLE;
            end
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end
      end

      default: begin
        state_n  = ST_IDLE;
        cnt_n    = 16'd0;
        period_n = PERIOD_MAX;
      end
    endcase

    if (step) begin
      phase_n = step_right ? (phase + 2'd1) : (phase - 2'd1);
    end

    ready_n = (state_n == ST_IDLE) && !joy_active;
  end

  // All state is registered. moving and delta_ready look one state ahead so
  // that they line up with the registered state.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      phase       <= 2'd0;
      cnt         <= 16'd0;
      period      <= PERIOD_MAX;
      pending     <= '0;
      dir         <= 1'b0;
      delta_ready <= 1'b0;
      moving      <= 1'b0;
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      cnt         <= cnt_n;
      period      <= period_n;
      pending     <= pending_n;
      dir         <= dir_n;
      delta_ready <= ready_n;
      moving      <= (state_n != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_steer_quad_gen.sv
// tb_steer_quad_gen
//   Directed bench for steer_quad_gen with MAX=8, MIN=2, RAMP=3.
//   A table of {inputs, edge count, expected outputs} covers the joystick
//   ramp, release, paddle play-out and joystick override. Hand-written
//   sequences cover the long negative delta, the ce-throttled ramp and an
//   asynchronous reset during paddle motion.

module tb_steer_quad_gen;

  logic       CLK = 1'b0;
  logic       reset;
  logic       ce;
  logic       left;
  logic       right;
  logic [7:0] delta;
  logic       delta_valid;
  logic       delta_ready;
  logic [1:0] steer;
  logic       moving;
  logic       dir;

  int checks = 0;
  int errors = 0;

  steer_quad_gen #(
    .CLKDIV_MAX(8),
    .CLKDIV_MIN(2),
    .RAMP_STEP (3),
    .DELTA_W   (8)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .ce         (ce),
    .left       (left),
    .right      (right),
    .delta      (delta),
    .delta_valid(delta_valid),
    .delta_ready(delta_ready),
    .steer      (steer),
    .moving     (moving),
    .dir        (dir)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       l;
    logic       r;
    logic       c;
    logic       v;
    logic [7:0] d;
    int         n;
    logic [1:0] exp_steer;
    logic       exp_moving;
    logic       exp_dir;
    logic       exp_ready;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic l, r, c, v, input logic [7:0] d, input int n,
                              input logic [1:0] s, input logic m, dr, rd);
    vec_t x;
    x.l = l; x.r = r; x.c = c; x.v = v; x.d = d; x.n = n;
    x.exp_steer = s; x.exp_moving = m; x.exp_dir = dr; x.exp_ready = rd;
    return x;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one vector's inputs, run its edges, and sample 1 ns after the last edge.
  task automatic apply_stimulus(input vec_t x);
    left = x.l; right = x.r; ce = x.c; delta_valid = x.v; delta = x.d;
    repeat (x.n) @(posedge CLK);
    #1;
  endtask

  task automatic run_edges(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    int         step_cnt;
    int         step_edges[$];
    logic [1:0] prev;
    logic       timed_out;

    //              l  r  ce v  delta  n  steer  mv dir rdy
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 1, 2'b00, 0, 0, 1)); // ready one edge after release
    vecs.push_back(mk(0, 1, 1, 0, 8'h00, 1, 2'b01, 1, 1, 0)); // right: immediate step
    vecs.push_back(mk(0, 1, 1, 0, 8'h00, 7, 2'b01, 1, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 8'h00, 1, 2'b11, 1, 1, 0)); // step after 8
    vecs.push_back(mk(0, 1, 1, 0, 8'h00, 4, 2'b11, 1, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 8'h00, 1, 2'b10, 1, 1, 0)); // step after 5
    vecs.push_back(mk(0, 1, 1, 0, 8'h00, 2, 2'b00, 1, 1, 0)); // step after 2 (floor)
    vecs.push_back(mk(0, 1, 1, 0, 8'h00, 2, 2'b01, 1, 1, 0)); // floor holds
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 1, 2'b01, 0, 1, 1)); // release
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 1, 2'b01, 0, 1, 1)); // phase held
    vecs.push_back(mk(1, 0, 1, 0, 8'h00, 1, 2'b00, 1, 0, 0)); // left: immediate step
    vecs.push_back(mk(1, 0, 1, 0, 8'h00, 7, 2'b00, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 8'h00, 1, 2'b10, 1, 0, 0)); // left wraps 00->10
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 1, 2'b10, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 8'h03, 1, 2'b10, 1, 1, 0)); // +3 accepted
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 1, 2'b00, 1, 1, 0)); // step 1
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 2, 2'b01, 1, 1, 0)); // step 2
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 1, 2'b01, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 1, 2'b11, 0, 1, 1)); // step 3, done
    vecs.push_back(mk(0, 0, 1, 1, 8'h00, 1, 2'b11, 0, 1, 1)); // zero delta discarded
    vecs.push_back(mk(1, 1, 1, 0, 8'h00, 3, 2'b11, 0, 1, 1)); // both keys = idle
    vecs.push_back(mk(0, 0, 1, 1, 8'h0A, 1, 2'b11, 1, 1, 0)); // +10 accepted
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 3, 2'b00, 1, 1, 0)); // two paddle steps
    vecs.push_back(mk(0, 1, 1, 0, 8'h00, 1, 2'b01, 1, 1, 0)); // joystick override step
    vecs.push_back(mk(0, 1, 1, 0, 8'h00, 7, 2'b01, 1, 1, 0)); // ramp restarted at 8
    vecs.push_back(mk(0, 1, 1, 0, 8'h00, 1, 2'b11, 1, 1, 0));
    vecs.push_back(mk(1, 0, 1, 0, 8'h00, 1, 2'b01, 1, 0, 0)); // reversal: immediate left
    vecs.push_back(mk(1, 1, 1, 0, 8'h00, 3, 2'b01, 0, 0, 1)); // both: idle, pending gone
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 2, 2'b01, 0, 0, 0)); // ce low: no entry
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 1, 2'b01, 0, 0, 1));

    reset = 1'b1; ce = 1'b1; left = 1'b0; right = 1'b0; delta = 8'h00; delta_valid = 1'b0;
    run_edges(2);
    check_output("reset steer", 32'(steer), 32'd0);
    check_output("reset moving", 32'(moving), 32'd0);
    check_output("reset ready", 32'(delta_ready), 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("row%0d steer", i), 32'(steer), 32'(vecs[i].exp_steer));
      check_output($sformatf("row%0d moving", i), 32'(moving), 32'(vecs[i].exp_moving));
      check_output($sformatf("row%0d dir", i), 32'(dir), 32'(vecs[i].exp_dir));
      check_output($sformatf("row%0d ready", i), 32'(delta_ready), 32'(vecs[i].exp_ready));
    end

    // delta = -128 must play out as exactly 128 left steps.
    delta = 8'h80; delta_valid = 1'b1; ce = 1'b1;
    run_edges(1);
    delta_valid = 1'b0; delta = 8'h00;
    step_cnt = 0; prev = steer; timed_out = 1'b1;
    for (int k = 0; k < 300; k++) begin
      run_edges(1);
      if (steer != prev) step_cnt++;
      prev = steer;
      if (!moving) begin
        timed_out = 1'b0;
        break;
      end
    end
    check_output("neg128 finished", 32'(timed_out), 32'd0);
    check_output("neg128 steps", 32'(step_cnt), 32'd128);
    check_output("neg128 steer", 32'(steer), 32'b01);
    check_output("neg128 dir", 32'(dir), 32'd0);

    // ce 1-in-4 with right held: steps at edges 0, 32, 52 and only on ce edges.
    right = 1'b1; prev = steer;
    for (int k = 0; k < 56; k++) begin
      ce = (k % 4 == 0);
      run_edges(1);
      if (steer != prev) begin
        step_edges.push_back(k);
        if (!ce) check_output($sformatf("ce0 step k%0d", k), 32'(ce), 32'd1);
      end
      prev = steer;
    end
    check_output("ce4 step count", 32'(step_edges.size()), 32'd3);
    if (step_edges.size() == 3) begin
      check_output("ce4 step0", 32'(step_edges[0]), 32'd0);
      check_output("ce4 step1", 32'(step_edges[1]), 32'd32);
      check_output("ce4 step2", 32'(step_edges[2]), 32'd52);
    end
    check_output("ce4 steer", 32'(steer), 32'b00);
    right = 1'b0; ce = 1'b1;
    run_edges(1);
    check_output("ce4 release moving", 32'(moving), 32'd0);

    // Async reset in the middle of a paddle motion.
    delta = 8'h05; delta_valid = 1'b1;
    run_edges(1);
    delta_valid = 1'b0; delta = 8'h00;
    run_edges(1);
    check_output("pre-reset steer", 32'(steer), 32'b01);
    check_output("pre-reset moving", 32'(moving), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_output("async reset steer", 32'(steer), 32'd0);
    check_output("async reset moving", 32'(moving), 32'd0);
    check_output("async reset ready", 32'(delta_ready), 32'd0);
    #3 reset = 1'b0;
    run_edges(6);
    check_output("post-reset steer", 32'(steer), 32'd0);
    check_output("post-reset moving", 32'(moving), 32'd0);
    check_output("post-reset ready", 32'(delta_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
